// File: rtl/eth_phy_mdio_ctrl.sv
// Ethernet PHY management controller: sequences the PHY hard reset, then runs one
// Clause-22 MDIO read or write frame per accepted request.
module eth_phy_mdio_ctrl #(
    parameter int CLK_DIV         = 10,
    parameter int PHY_RST_CYCLES  = 2500,
    parameter int PHY_WAIT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [4:0]  req_phyad,
    input  logic [4:0]  req_regad,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        phy_rst_n,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam int MAX_A = (CLK_DIV > PHY_RST_CYCLES) ? CLK_DIV : PHY_RST_CYCLES;
    localparam int MAX_C = (MAX_A > PHY_WAIT_CYCLES) ? MAX_A : PHY_WAIT_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(PHY_RST_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(PHY_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        RST_PHY,
        WAIT_PHY,
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div;
    logic [5:0]    r_bit;
    logic          r_mdc;
    logic          r_mdo;
    logic          r_oe;
    logic          r_ready;
    logic          r_busy;
    logic          r_phy_rst_n;
    logic          r_rsp_valid;
    logic [15:0]   r_rdata;
    logic          r_err;

    logic          r_wr;
    logic [4:0]    r_phyad;
    logic [4:0]    r_regad;
    logic [15:0]   r_wdata;
    logic [15:0]   r_shift;
    logic          r_err_sh;

    logic          w_accept;
    logic          w_tick;
    logic          w_rise;
    logic          w_fall;
    logic          w_last;
    logic [5:0]    w_bit_nxt;
    logic [63:0]   w_frame;
    logic          w_frame_bit;
    logic          w_ready_d;
    logic          w_busy_d;
    logic          w_phy_rst_n_d;
    logic          w_rsp_valid_d;

    assign w_accept    = req_valid && r_ready;
    assign w_tick      = (r_state == SHIFT) && (r_div == DIV_LAST);
    assign w_rise      = w_tick && !r_mdc;
    assign w_fall      = w_tick && r_mdc;
    assign w_last      = w_fall && (r_bit == 6'd63);
    assign w_bit_nxt   = r_bit + 6'd1;

    // Frame bit 0 sits at the MSB; read frames carry 1s where the PHY owns the line.
    assign w_frame     = {32'hFFFF_FFFF, 2'b01, (r_wr ? 2'b01 : 2'b10), r_phyad, r_regad,
                          (r_wr ? 2'b10 : 2'b11), (r_wr ? r_wdata : 16'hFFFF)};
    assign w_frame_bit = w_frame[6'd63 - w_bit_nxt];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= RST_PHY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RST_PHY:  if (r_cnt == RST_LAST)  w_state_nxt = WAIT_PHY;
            WAIT_PHY: if (r_cnt == WAIT_LAST) w_state_nxt = IDLE;
            IDLE:     if (w_accept)           w_state_nxt = SHIFT;
            SHIFT:    if (w_last)             w_state_nxt = DONE;
            DONE:                             w_state_nxt = IDLE;
            default:                          w_state_nxt = RST_PHY;
        endcase
    end

    // Status outputs are registered from the state being entered, so they line up with it.
    always_comb begin
        w_ready_d     = (w_state_nxt == IDLE);
        w_busy_d      = (w_state_nxt != IDLE);
        w_phy_rst_n_d = (w_state_nxt != RST_PHY);
        w_rsp_valid_d = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_div       <= '0;
            r_bit       <= '0;
            r_mdc       <= 1'b0;
            r_mdo       <= 1'b1;
            r_oe        <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_phy_rst_n <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_wr        <= 1'b0;
            r_phyad     <= '0;
            r_regad     <= '0;
            r_wdata     <= '0;
            r_shift     <= '0;
            r_err_sh    <= 1'b0;
        end else begin
            r_ready     <= w_ready_d;
            r_busy      <= w_busy_d;
            r_phy_rst_n <= w_phy_rst_n_d;
            r_rsp_valid <= w_rsp_valid_d;
            case (r_state)
                RST_PHY: begin
                    r_cnt <= (r_cnt == RST_LAST) ? '0 : r_cnt + CW'(1);
                end
                WAIT_PHY: begin
                    r_cnt <= (r_cnt == WAIT_LAST) ? '0 : r_cnt + CW'(1);
                end
                IDLE: begin
                    if (w_accept) begin
                        r_wr    <= req_wr;
                        r_phyad <= req_phyad;
                        r_regad <= req_regad;
                        r_wdata <= req_wdata;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_mdc   <= 1'b0;
                        r_oe    <= 1'b1;
                        r_mdo   <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_div <= '0;
                        r_mdc <= ~r_mdc;
                    end else begin
                        r_div <= r_div + CW'(1);
                    end
                    // Read data is captured on the clk edge that raises mdc.
                    if (w_rise && !r_wr) begin
                        if (r_bit == 6'd47) begin
                            r_err_sh <= mdio_i;
                        end else if (r_bit >= 6'd48) begin
                            r_shift <= {r_shift[14:0], mdio_i};
                        end
                    end
                    if (w_fall) begin
                        if (r_bit == 6'd63) begin
                            r_oe    <= 1'b0;
                            r_mdo   <= 1'b1;
                            r_rdata <= r_wr ? 16'h0000 : r_shift;
                            r_err   <= r_wr ? 1'b0 : r_err_sh;
                        end else begin
                            r_bit <= w_bit_nxt;
                            r_mdo <= w_frame_bit;
                            r_oe  <= r_wr || (w_bit_nxt < 6'd46);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign phy_rst_n = r_phy_rst_n;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign mdc       = r_mdc;
    assign mdio_o    = r_mdo;
    assign mdio_oe   = r_oe;

endmodule

// File: tb/tb_eth_phy_mdio_ctrl.sv
// Directed bench for eth_phy_mdio_ctrl: reset sequencing, write/read frames, missing PHY,
// back-to-back requests and reset mid-frame, against hand-computed frames.
module tb_eth_phy_mdio_ctrl;

    localparam int CLK_DIV         = 4;
    localparam int PHY_RST_CYCLES  = 16;
    localparam int PHY_WAIT_CYCLES = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [4:0]  req_phyad = '0;
    logic [4:0]  req_regad = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        phy_rst_n;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    logic        phyEn = 1'b0;
    logic        phyVal = 1'b1;

    int vecCount = 0;
    int missCount = 0;

    eth_phy_mdio_ctrl #(
        .CLK_DIV        (CLK_DIV),
        .PHY_RST_CYCLES (PHY_RST_CYCLES),
        .PHY_WAIT_CYCLES(PHY_WAIT_CYCLES)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr   (req_wr),
        .req_phyad(req_phyad),
        .req_regad(req_regad),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .phy_rst_n(phy_rst_n),
        .mdc      (mdc),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe),
        .mdio_i   (mdio_i)
    );

    // Pad model: FPGA driver wins, else the PHY model, else the pull-up.
    assign mdio_i = mdio_oe ? mdio_o : (phyEn ? phyVal : 1'b1);

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [4:0] phyad, input logic [4:0] regad,
                                 input logic [15:0] wdata);
        req_wr    = wr;
        req_phyad = phyad;
        req_regad = regad;
        req_wdata = wdata;
        req_valid = 1'b1;
    endtask

    // Called at a negedge; releases reset there (cycle 0) and walks the boot sequence to cycle 24.
    task automatic checkBoot(input string name);
        rstn = 1'b1;
        #1;
        checkOutput({name, ".phyRstN0"}, 64'(phy_rst_n), 64'd0);
        checkOutput({name, ".busy0"},    64'(busy),      64'd1);
        checkOutput({name, ".ready0"},   64'(req_ready), 64'd0);
        checkOutput({name, ".mdc0"},     64'(mdc),       64'd0);
        checkOutput({name, ".mdioO0"},   64'(mdio_o),    64'd1);
        checkOutput({name, ".mdioOe0"},  64'(mdio_oe),   64'd0);
        checkOutput({name, ".rdata0"},   64'(rsp_rdata), 64'd0);
        checkOutput({name, ".err0"},     64'(rsp_err),   64'd0);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            checkOutput({name, ".rspValid"}, 64'(rsp_valid), 64'd0);
            if (cyc == 15) checkOutput({name, ".phyRstN15"}, 64'(phy_rst_n), 64'd0);
            if (cyc == 16) checkOutput({name, ".phyRstN16"}, 64'(phy_rst_n), 64'd1);
            if (cyc == 23) begin
                checkOutput({name, ".ready23"}, 64'(req_ready), 64'd0);
                checkOutput({name, ".busy23"},  64'(busy),      64'd1);
            end
            if (cyc == 24) begin
                checkOutput({name, ".ready24"}, 64'(req_ready), 64'd1);
                checkOutput({name, ".busy24"},  64'(busy),      64'd0);
            end
        end
    endtask

    // Entered at the negedge of the acceptance cycle T; returns at the negedge of T+514.
    task automatic runFrame(input string name, input logic [63:0] expFrame, input logic isRead,
                            input logic phyDrive, input logic [15:0] phyData,
                            input logic [15:0] expRdata, input logic expErr,
                            input logic holdNext, input logic nWr, input logic [4:0] nPhy,
                            input logic [4:0] nReg, input logic [15:0] nWdata);
        int k;
        int p;
        logic [5:0] fIdx;
        logic [3:0] dIdx;
        for (int c = 1; c <= 514; c++) begin
            @(negedge clk);
            if (c <= 512) begin
                k = (c - 1) / 8;
                p = (c - 1) % 8;
                if (p == 0 && isRead && phyDrive) begin
                    if (k == 47) begin
                        phyEn  = 1'b1;
                        phyVal = 1'b0;
                    end else if (k >= 48) begin
                        dIdx   = 4'(63 - k);
                        phyEn  = 1'b1;
                        phyVal = phyData[dIdx];
                    end
                end
                checkOutput({name, ".mdc"},      64'(mdc),       (p >= 4) ? 64'd1 : 64'd0);
                checkOutput({name, ".rspValid"}, 64'(rsp_valid), 64'd0);
                if (p == 0) begin
                    checkOutput({name, ".ready"}, 64'(req_ready), 64'd0);
                    checkOutput({name, ".busy"},  64'(busy),      64'd1);
                    checkOutput({name, ".mdioOe"}, 64'(mdio_oe),
                                (!isRead || k < 46) ? 64'd1 : 64'd0);
                    if (!isRead || k < 46) begin
                        fIdx = 6'(63 - k);
                        checkOutput({name, ".mdioO"}, 64'(mdio_o), 64'(expFrame[fIdx]));
                    end
                end
            end else if (c == 513) begin
                phyEn = 1'b0;
                checkOutput({name, ".rspValidPulse"}, 64'(rsp_valid), 64'd1);
                checkOutput({name, ".rdata"},         64'(rsp_rdata), 64'(expRdata));
                checkOutput({name, ".err"},           64'(rsp_err),   64'(expErr));
                checkOutput({name, ".mdcDone"},       64'(mdc),       64'd0);
                checkOutput({name, ".mdioOeDone"},    64'(mdio_oe),   64'd0);
                checkOutput({name, ".mdioODone"},     64'(mdio_o),    64'd1);
                checkOutput({name, ".readyDone"},     64'(req_ready), 64'd0);
            end else begin
                checkOutput({name, ".rspValidEnd"}, 64'(rsp_valid), 64'd0);
                checkOutput({name, ".readyIdle"},   64'(req_ready), 64'd1);
                checkOutput({name, ".busyIdle"},    64'(busy),      64'd0);
                checkOutput({name, ".rdataHeld"},   64'(rsp_rdata), 64'(expRdata));
            end
            if (c == 1) begin
                if (holdNext) applyStimulus(nWr, nPhy, nReg, nWdata);
                else req_valid = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst.ready",    64'(req_ready), 64'd0);
        checkOutput("rst.busy",     64'(busy),      64'd1);
        checkOutput("rst.phyRstN",  64'(phy_rst_n), 64'd0);
        checkOutput("rst.rspValid", 64'(rsp_valid), 64'd0);
        checkOutput("rst.mdioOe",   64'(mdio_oe),   64'd0);
        checkOutput("rst.mdioO",    64'(mdio_o),    64'd1);

        checkBoot("boot");

        applyStimulus(1'b1, 5'd1, 5'd0, 16'h1140);
        runFrame("wr1", 64'hFFFF_FFFF_5082_1140, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                 1'b0, 1'b0, 5'd0, 5'd0, 16'h0000);

        applyStimulus(1'b0, 5'd1, 5'd2, 16'hDEAD);
        runFrame("rd1", 64'hFFFF_FFFF_608B_FFFF, 1'b1, 1'b1, 16'h0141, 16'h0141, 1'b0,
                 1'b0, 1'b0, 5'd0, 5'd0, 16'h0000);

        applyStimulus(1'b0, 5'd7, 5'd3, 16'h1234);
        runFrame("rdNoPhy", 64'hFFFF_FFFF_638F_FFFF, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b1,
                 1'b0, 1'b0, 5'd0, 5'd0, 16'h0000);

        // req_valid stays high across both frames; the second must start right after rsp_valid.
        applyStimulus(1'b1, 5'd3, 5'd4, 16'hA5C3);
        runFrame("b2bWr", 64'hFFFF_FFFF_5192_A5C3, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                 1'b1, 1'b0, 5'd2, 5'd1, 16'h5555);
        runFrame("b2bRd", 64'hFFFF_FFFF_6107_FFFF, 1'b1, 1'b1, 16'h8001, 16'h8001, 1'b0,
                 1'b0, 1'b0, 5'd0, 5'd0, 16'h0000);

        applyStimulus(1'b1, 5'd5, 5'd9, 16'hBEEF);
        for (int c = 1; c <= 166; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        checkOutput("abort.preMdc",  64'(mdc),     64'd1);
        checkOutput("abort.preOe",   64'(mdio_oe), 64'd1);
        rstn = 1'b0;
        #1;
        checkOutput("abort.mdioOe",  64'(mdio_oe),   64'd0);
        checkOutput("abort.mdc",     64'(mdc),       64'd0);
        checkOutput("abort.phyRstN", 64'(phy_rst_n), 64'd0);
        checkOutput("abort.mdioO",   64'(mdio_o),    64'd1);
        checkOutput("abort.busy",    64'(busy),      64'd1);
        checkOutput("abort.ready",   64'(req_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort.rspValid", 64'(rsp_valid), 64'd0);
        end
        checkBoot("reboot");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
